// File: rtl/seg7_scan_driver_if.sv
// Bundle between seg7_scan_driver and its user: the load/config inputs and
// the scanned display pin outputs.
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic                  en;
  logic                  load;
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  hex_mode;
  logic                  lz_blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   dig_sel;
  logic                  frame_done;

  modport master (output en, load, data, dp_in, hex_mode, lz_blank,
                  input  seg, dp, dig_sel, frame_done);
  modport slave  (input  en, load, data, dp_in, hex_mode, lz_blank,
                  output seg, dp, dig_sel, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: hex/BCD glyphs, leading-zero
// blanking, per-digit dp, frame-boundary (tear-free) load and blank gap.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 8,
  parameter int DWELL          = 1000,
  parameter int GAP            = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {s_idle = 2'd0, s_gap = 2'd1, s_show = 2'd2} state_t;

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic                  hex;
    logic                  lz;
  } cfg_t;

  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    if (!hex && (nib > 4'd9)) begin
      g = 7'b1110110;
    end else begin
      case (nib)
        4'h0: g = 7'b1111110;
        4'h1: g = 7'b0110000;
        4'h2: g = 7'b1101101;
        4'h3: g = 7'b1111001;
        4'h4: g = 7'b0110011;
        4'h5: g = 7'b1011011;
        4'h6: g = 7'b1011111;
        4'h7: g = 7'b1110000;
        4'h8: g = 7'b1111111;
        4'h9: g = 7'b1111011;
        4'hA: g = 7'b1110111;
        4'hB: g = 7'b0011111;
        4'hC: g = 7'b1001110;
        4'hD: g = 7'b0111101;
        4'hE: g = 7'b1001111;
        4'hF: g = 7'b1000111;
        default: g = 7'b0000000;
      endcase
    end
    return g;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [IW-1:0]       idx_r, idx_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  cfg_t                pend_r, pend_nxt_s, act_r, act_nxt_s, cfg_in_s;
  logic [6:0]          seg_r, seg_raw_s, seg_nxt_s;
  logic                dp_r, dp_raw_s, dp_nxt_s;
  logic [N_DIGITS-1:0] dig_sel_r, dig_nxt_s, onehot_s, blank_s;
  logic                frame_done_r;
  logic                last_show_s, frame_end_s, boundary_s, show_s;
  logic                uz_s, blank_sel_s, dp_sel_s;
  logic [3:0]          nib_s;

  assign cfg_in_s    = cfg_t'({bus.data, bus.dp_in, bus.hex_mode, bus.lz_blank});
  assign last_show_s = (state_r == s_show) && (cnt_r == CW'(DWELL - 1));
  assign frame_end_s = last_show_s && (idx_r == IW'(N_DIGITS - 1));
  // Frame boundary: wrap into digit 0, or (re)start from idle.
  assign boundary_s  = bus.en && (frame_end_s || (state_r == s_idle));

  // Scan sequencer next state.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    if (!bus.en) begin
      state_nxt_s = s_idle;
      idx_nxt_s   = '0;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        s_idle: begin
          idx_nxt_s   = '0;
          cnt_nxt_s   = '0;
          state_nxt_s = (GAP > 0) ? s_gap : s_show;
        end
        s_gap: begin
          if (cnt_r == CW'(GAP - 1)) begin
            cnt_nxt_s   = '0;
            state_nxt_s = s_show;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        s_show: begin
          if (last_show_s) begin
            cnt_nxt_s   = '0;
            idx_nxt_s   = frame_end_s ? '0 : idx_r + IW'(1);
            state_nxt_s = (GAP > 0) ? s_gap : s_show;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_nxt_s = s_idle;
          idx_nxt_s   = '0;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Pending/active config; a load on the boundary edge lands directly in active.
  always_comb begin
    pend_nxt_s = pend_r;
    act_nxt_s  = act_r;
    if (bus.load) begin
      pend_nxt_s = cfg_in_s;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (boundary_s) begin
      act_nxt_s = pend_nxt_s;
    end else begin
      act_nxt_s = act_r;
    end
  end

  // Pin values for the cycle after this edge, from next state and next config.
  always_comb begin
    uz_s  = 1'b1;
    nib_s = 4'h0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      uz_s       = uz_s && (act_nxt_s.data[4*k +: 4] == 4'h0);
      blank_s[k] = (k != 0) && uz_s;
      onehot_s[k] = (idx_nxt_s == IW'(k));
      nib_s      = nib_s | ({4{onehot_s[k]}} & act_nxt_s.data[4*k +: 4]);
    end
    blank_sel_s = |(onehot_s & blank_s);
    dp_sel_s    = |(onehot_s & act_nxt_s.dp);
    show_s      = (state_nxt_s == s_show);
    if (show_s) begin
      seg_raw_s = (act_nxt_s.lz && blank_sel_s) ? 7'h00 : glyph(nib_s, act_nxt_s.hex);
      dp_raw_s  = dp_sel_s;
    end else begin
      seg_raw_s = 7'h00;
      dp_raw_s  = 1'b0;
    end
    seg_nxt_s = SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
    dp_nxt_s  = SEG_ACTIVE_LOW ? ~dp_raw_s : dp_raw_s;
    dig_nxt_s = ~(onehot_s & {N_DIGITS{show_s}});
  end

  // State, config and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= s_idle;
      idx_r        <= '0;
      cnt_r        <= '0;
      pend_r       <= '0;
      act_r        <= '0;
      seg_r        <= SEG_OFF;
      dp_r         <= DP_OFF;
      dig_sel_r    <= '1;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      cnt_r        <= cnt_nxt_s;
      pend_r       <= pend_nxt_s;
      act_r        <= act_nxt_s;
      seg_r        <= seg_nxt_s;
      dp_r         <= dp_nxt_s;
      dig_sel_r    <= dig_nxt_s;
      frame_done_r <= frame_end_s && bus.en;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.dig_sel    = dig_sel_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two configurations (with gap / active-high, and
// no gap / active-low) scored every cycle against a frame-position model.
module tb_seg7_scan_driver;
  localparam int NDIG  = 4;
  localparam int DWELL = 3;
  localparam int GAP_A = 1;
  localparam int GAP_B = 0;
  localparam logic [111:0] GTAB = {7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
                                   7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
                                   7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
                                   7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, load = 1'b0, hex = 1'b1, lz = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dpv = 4'h0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] p_data;
  logic [3:0]  p_dp;
  logic        p_hex, p_lz;
  logic [15:0] a_data [2];
  logic [3:0]  a_dp [2];
  logic        a_hex [2], a_lz [2];
  bit          run [2];
  int          jpos [2];
  logic [12:0] exp_q_a [$];
  logic [12:0] exp_q_b [$];

  seg7_scan_driver_if #(.N_DIGITS(NDIG)) if_a ();
  seg7_scan_driver_if #(.N_DIGITS(NDIG)) if_b ();

  assign if_a.en = en;   assign if_a.load = load;   assign if_a.data = data;
  assign if_a.dp_in = dpv; assign if_a.hex_mode = hex; assign if_a.lz_blank = lz;
  assign if_b.en = en;   assign if_b.load = load;   assign if_b.data = data;
  assign if_b.dp_in = dpv; assign if_b.hex_mode = hex; assign if_b.lz_blank = lz;

  seg7_scan_driver #(.N_DIGITS(NDIG), .DWELL(DWELL), .GAP(GAP_A), .SEG_ACTIVE_LOW(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  seg7_scan_driver #(.N_DIGITS(NDIG), .DWELL(DWELL), .GAP(GAP_B), .SEG_ACTIVE_LOW(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] n, input logic h);
    logic [111:0] t;
    t = GTAB;
    if (!h && (n > 4'd9)) return 7'b1110110;
    else return t[n*7 +: 7];
  endfunction

  // Expected {dig_sel, seg, dp, frame_done} from position within the running frame.
  function automatic logic [12:0] model_out(input int u);
    int gp, ln, pos, dig;
    logic [6:0] sg;
    logic [3:0] ds;
    logic d, fd;
    gp = (u == 0) ? GAP_A : GAP_B;
    ln = DWELL + gp;
    sg = 7'd0; d = 1'b0; ds = 4'hF; fd = 1'b0;
    if (run[u]) begin
      pos = jpos[u] % ln;
      dig = (jpos[u] / ln) % NDIG;
      fd  = (jpos[u] > 0) && (jpos[u] % (NDIG * ln) == 0);
      if (pos >= gp) begin
        ds[dig] = 1'b0;
        d = a_dp[u][dig];
        if (a_lz[u] && (dig != 0) && ((a_data[u] >> (4 * dig)) == 16'd0)) sg = 7'd0;
        else sg = glyph_of(a_data[u][4*dig +: 4], a_hex[u]);
      end
    end
    if (u == 1) begin
      sg = ~sg;
      d  = ~d;
    end
    return {ds, sg, d, fd};
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      p_data = 16'h0; p_dp = 4'h0; p_hex = 1'b0; p_lz = 1'b0;
      for (int u = 0; u < 2; u++) begin
        a_data[u] = 16'h0; a_dp[u] = 4'h0; a_hex[u] = 1'b0; a_lz[u] = 1'b0;
        run[u] = 1'b0; jpos[u] = 0;
      end
    end else begin
      if (load) begin
        p_data = data; p_dp = dpv; p_hex = hex; p_lz = lz;
      end
      for (int u = 0; u < 2; u++) begin
        if (!en) run[u] = 1'b0;
        else if (!run[u]) begin
          run[u] = 1'b1;
          jpos[u] = 0;
        end else jpos[u]++;
        if (run[u] && (jpos[u] % (NDIG * (DWELL + ((u == 0) ? GAP_A : GAP_B))) == 0)) begin
          a_data[u] = p_data; a_dp[u] = p_dp; a_hex[u] = p_hex; a_lz[u] = p_lz;
        end
      end
    end
    exp_q_a.push_back(model_out(0));
    exp_q_b.push_back(model_out(1));
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (exp_q_a.size() > 0)
      check("scan_a", 32'({if_a.dig_sel, if_a.seg, if_a.dp, if_a.frame_done}), 32'(exp_q_a.pop_front()));
    if (exp_q_b.size() > 0)
      check("scan_b", 32'({if_b.dig_sel, if_b.seg, if_b.dp, if_b.frame_done}), 32'(exp_q_b.pop_front()));
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic h, input logic l);
    data = d; dpv = p; hex = h; lz = l; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(4);
    do_load(16'h1234, 4'b0100, 1'b1, 1'b0);
    en = 1'b1;
    step(40);
    do_load(16'h5555, 4'b0001, 1'b1, 1'b0);
    step(3);
    do_load(16'hC0DE, 4'b1000, 1'b1, 1'b0);
    step(40);
    do_load(16'h00A7, 4'b0000, 1'b0, 1'b1);
    step(40);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(30);
    do_load(16'h0000, 4'b0000, 1'b1, 1'b1);
    step(30);
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(1, 12));
      if ($urandom_range(0, 5) == 0) en = ~en;
      else do_load(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end
    en = 1'b1;
    step(6);
    // Asynchronous reset mid-show: outputs go dark without waiting for an edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dig_a", 32'(if_a.dig_sel), 32'(4'hF));
    check("rst_seg_a", 32'(if_a.seg), 32'(7'h00));
    check("rst_fd_a", 32'(if_a.frame_done), 32'(1'b0));
    check("rst_seg_b", 32'(if_b.seg), 32'(7'h7F));
    check("rst_dig_b", 32'(if_b.dig_sel), 32'(4'hF));
    step(2);
    rst_n = 1'b1;
    step(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
